uart_rx_fifo: RTL
=================

# uart_rx_fifo

Host-side UART receiver for the FPGA test harness. It deserializes 8N1 frames from the board's USB-UART line (`uart_txd_in`) in the 50 MHz domain and buffers the bytes in a small FIFO. Bytes leave on a valid/ready byte stream that drives the design's input pins, so the host PC can stimulate the CPU. It is the upstream counterpart of the CPU's UART transmit path.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 434: clock cycles per bit (50 MHz / 115200); legal range ≥ 4.
- `FIFO_DEPTH`, default 8: byte entries; must be a power of 2, ≥ 2.

Ports:
- `clk` in 1: 50 MHz system clock. All logic is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `rx_in` in 1: asynchronous serial line. Idles high.
- `m_data` out 8: head-of-FIFO byte.
- `m_valid` out 1: `m_data` holds a valid byte.
- `m_ready` in 1: consumer accepts the byte. A transfer happens on any cycle where `m_valid && m_ready`.
- `fifo_count` out $clog2(FIFO_DEPTH)+1: number of bytes stored.
- `frame_err` out 1: one-cycle pulse when a stop bit is sampled low.
- `overflow` out 1: one-cycle pulse when a received byte is dropped because the FIFO is full.

## Operation
- **Synchronizer:** `rx_in` passes through a 2-FF synchronizer whose flops reset to 1. All references to "rx" below mean the synchronizer output.
- **Bit counter:** `cnt` counts clock cycles within the current state and clears on every state change.
- **FSM:**
  - IDLE: when rx=0, go to START.
  - START: when `cnt == CLKS_PER_BIT/2 - 1` (integer division), sample rx. If rx=0, go to DATA. If rx=1, the start bit was a glitch; go to IDLE with no output.
  - DATA: when `cnt == CLKS_PER_BIT - 1`, sample rx into a shift register, LSB first. After 8 samples, go to STOP.
  - STOP: when `cnt == CLKS_PER_BIT - 1`, sample rx.
    - rx=1: push the byte and go to IDLE immediately (mid-stop-bit, which allows back-to-back frames).
    - rx=0: pulse `frame_err`, discard the byte, go to BREAK.
  - BREAK: wait for rx=1, then go to IDLE. A held-low line produces exactly one `frame_err`.
- **FIFO:**
  - Circular buffer with read/write pointers one bit wider than the address; full and empty are derived from the pointers.
  - First-word fall-through: `m_data` is the entry at the read pointer, and `m_valid` is high whenever the FIFO is not empty.
  - While `m_valid && !m_ready`, `m_data` stays stable.
  - Push while full:
    - With a pop on the same cycle: the push is accepted and the count is unchanged.
    - With no pop: the byte is dropped and `overflow` pulses for one cycle.
  - Push and pop on the same cycle when not full: both happen and the count is unchanged.
  - Pop while empty is ignored.
- **Reset:** `rst` aborts any frame in progress. On the next edge:
  - FSM returns to IDLE.
  - Synchronizer flops go to 1.
  - FIFO is emptied.
  - Reset values: `m_valid`=0, `fifo_count`=0, `frame_err`=0, `overflow`=0, `m_data`=8'h00.

## Timing
- Synchronizer delay: 2 cycles.
- Let E be the first cycle in which rx=0 is seen in IDLE (the IDLE→START transition edge).
  - START sample at E + CLKS_PER_BIT/2.
  - Data bit k (k = 0..7) sampled at E + CLKS_PER_BIT/2 + (k+1)·CLKS_PER_BIT.
  - Stop sample at E + CLKS_PER_BIT/2 + 9·CLKS_PER_BIT.
  - The FIFO write occurs on that stop-sample edge; `m_valid` and `fifo_count` reflect it on the following cycle.
- `frame_err` and `overflow` are asserted for exactly the one cycle after the stop-sample edge.
- Sustained throughput is one byte per 10 bit times. The FSM re-arms 0.5 bit before the frame ends, which tolerates a host clock up to about 4% fast.
- A pop affects `fifo_count` and `m_data` on the next cycle.

## Test plan
All scenarios use `CLKS_PER_BIT=8`, `FIFO_DEPTH=4`, and an ideal 8-cycle-per-bit driver.
- **Single byte:** send 8'hA5 with `m_ready`=0 → `m_valid` rises 1 cycle after the stop sample; `m_data`=8'hA5; `fifo_count`=1. Then raise `m_ready` for one cycle → `m_valid`=0, `fifo_count`=0.
- **Back-to-back and overflow:** send 8'h01..8'h05 back-to-back with `m_ready`=0 → `fifo_count` saturates at 4; `overflow` pulses once on byte 5; reading drains exactly 01, 02, 03, 04 in order.
- **Full with simultaneous pop:** with the FIFO full, hold `m_ready`=1 on the cycle byte 5 is pushed → no `overflow`; `fifo_count` stays 4; byte 5 is the last entry read.
- **Framing error:** send 8'h3C with the stop bit low, held low for 30 cycles, then idle high → one `frame_err` pulse; `fifo_count` unchanged; the next good frame 8'h7E is received correctly.
- **Glitch:** drive `rx_in` low for 3 cycles, then high → no byte, no error, FSM back in IDLE. Then send 8'hFF → received correctly.
- **Mid-frame reset:** assert `rst` for 1 cycle during data bit 4 of a frame while the FIFO holds 2 bytes → the next cycle shows `fifo_count`=0 and `m_valid`=0. The remaining bits of the aborted frame produce no byte, or at most framing-error/garbage behaviour only after a valid new start. A clean frame 8'h55 sent after 12 idle bit times is received as 8'h55.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver feeding a first-word-fall-through byte FIFO.
// Ports: clk, rst (sync, active-high), rx_in (async serial line), m_data/m_valid/m_ready
//   (byte stream out), fifo_count (stored bytes), frame_err/overflow (1-cycle pulses).
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rx_in,
  output logic [7:0]                    m_data,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          frame_err,
  output logic                          overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  logic [1:0]    r_sync;
  logic          w_rx;
  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_cnt;
  logic [7:0]    r_shift;
  logic [2:0]    r_bits;
  logic          r_ferr;
  logic          w_half;
  logic          w_tick;
  logic          w_sample;
  logic          w_push;
  logic          w_ferr;

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW:0]   r_wptr;
  logic [AW:0]   r_rptr;
  logic          r_ovf;
  logic          w_full;
  logic          w_empty;
  logic          w_pop;
  logic          w_wr;
  logic          w_drop;

  assign w_rx   = r_sync[1];
  assign w_half = (r_cnt == HALF);
  assign w_tick = (r_cnt == FULL);

  always_comb begin
    w_next   = r_state;
    w_sample = 1'b0;
    w_push   = 1'b0;
    w_ferr   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (!w_rx) w_next = S_START;
      end
      S_START: begin
        // A start bit that is high again at mid-bit is noise.
        if (w_half) w_next = w_rx ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (w_tick) begin
          w_sample = 1'b1;
          if (r_bits == 3'd7) w_next = S_STOP;
        end
      end
      S_STOP: begin
        // Leave at mid-stop-bit so the next start edge is not missed.
        if (w_tick) begin
          if (w_rx) begin
            w_push = 1'b1;
            w_next = S_IDLE;
          end else begin
            w_ferr = 1'b1;
            w_next = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        if (w_rx) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync  <= 2'b11;
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_shift <= 8'h00;
      r_bits  <= 3'd0;
      r_ferr  <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], rx_in};
      r_state <= w_next;
      // Restart the bit timer on state change and on every data bit.
      if (w_next != r_state || (r_state == S_DATA && w_tick))
        r_cnt <= '0;
      else
        r_cnt <= r_cnt + 1'b1;
      // Eight samples wrap r_bits back to zero for the next frame.
      if (w_sample) begin
        r_shift <= {w_rx, r_shift[7:1]};
        r_bits  <= r_bits + 3'd1;
      end
      r_ferr  <= w_ferr;
    end
  end

  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[AW] != r_rptr[AW]) &&
                   (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_pop   = m_ready && !w_empty;
  // A pop frees the slot on the same edge, so a full FIFO still accepts.
  assign w_wr    = w_push && (!w_full || w_pop);
  assign w_drop  = w_push && w_full && !w_pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_ovf  <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= 8'h00;
    end else begin
      if (w_wr) begin
        r_mem[r_wptr[AW-1:0]] <= r_shift;
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      r_ovf <= w_drop;
    end
  end

  assign m_data     = r_mem[r_rptr[AW-1:0]];
  assign m_valid    = !w_empty;
  assign fifo_count = r_wptr - r_rptr;
  assign frame_err  = r_ferr;
  assign overflow   = r_ovf;

endmodule
